// File: rtl/memory_unit_if.sv
// memory_unit_if: RAM control strobes from the control block.
// Ports: nLma, nLmd, nLr, nCE (all active-low, master drives).
interface memory_unit_if;
   logic nLma;
   logic nLmd;
   logic nLr;
   logic nCE;

   modport master (
      output nLma,
      output nLmd,
      output nLr,
      output nCE
   );

   modport slave (
      input nLma,
      input nLmd,
      input nLr,
      input nCE
   );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: MAR, MDR and 16x8 RAM on the CPU bus, plus a
// nibble-serial loader.
// Ports: clk, rst_n; bus (tristate); ctl (nLma/nLmd/nLr/nCE);
// prog_en, prog_strobe, prog_nibble in; prog_addr, prog_hi and
// mem_word (RAM[MAR]) out.
module memory_unit #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   inout  wire  [7:0]        bus,
   memory_unit_if.slave      ctl,
   input  logic              prog_en,
   input  logic              prog_strobe,
   input  logic [3:0]        prog_nibble,
   output logic [ADDR_W-1:0] prog_addr,
   output logic              prog_hi,
   output logic [7:0]        mem_word
);

   typedef enum logic {LO, HI} ld_state_t;

   logic [7:0]             ram [DEPTH];
   logic [ADDR_W-1:0]      mar;
   logic [7:0]             mdr;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   ev;
   ld_state_t              state_q, state_d;
   logic [3:0]             lo_q, lo_d;
   logic [ADDR_W-1:0]      addr_d;
   logic                   prog_wr;
   logic                   cpu_wr;
   logic                   rd_en;

   assign cpu_wr   = ~prog_en & ~ctl.nLr;
   assign rd_en    = ~prog_en & ~ctl.nCE;
   assign mem_word = ram[mar];
   assign bus      = rd_en ? ram[mar] : 8'bz;
   assign prog_hi  = (state_q == HI);

   // Edge flop sits after the last sync stage: one-cycle pulse.
   assign ev = sync_q[SYNC_STAGES-1] & ~edge_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= SYNC_STAGES'({sync_q, prog_strobe});
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mar <= '0;
         mdr <= '0;
      end else if (!prog_en) begin
         if (!ctl.nLma) mar <= bus[ADDR_W-1:0];
         if (!ctl.nLmd) mdr <= bus;
      end
   end

   // prog_wr and cpu_wr are exclusive through prog_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else if (prog_wr) begin
         ram[prog_addr] <= {prog_nibble, lo_q};
      end else if (cpu_wr) begin
         ram[mar] <= mdr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LO;
         lo_q      <= '0;
         prog_addr <= '0;
      end else begin
         state_q   <= state_d;
         lo_q      <= lo_d;
         prog_addr <= addr_d;
      end
   end

   // Leaving programming mode drops any half-loaded byte.
   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      addr_d  = prog_addr;
      prog_wr = 1'b0;
      if (!prog_en) begin
         state_d = LO;
         addr_d  = '0;
      end else if (ev) begin
         unique case (state_q)
            LO: begin
               lo_d    = prog_nibble;
               state_d = HI;
            end
            HI: begin
               prog_wr = 1'b1;
               addr_d  = prog_addr + ADDR_W'(1);
               state_d = LO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed vectors for memory_unit.
// Ports: none (drives clk, rst_n, ctl, bus, prog pins).
module tb_memory_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       prog_en;
   logic       prog_strobe;
   logic [3:0] prog_nibble;
   logic [3:0] prog_addr;
   logic       prog_hi;
   logic [7:0] mem_word;
   logic       drv_en;
   logic [7:0] drv;
   wire  [7:0] bus;

   int checks   = 0;
   int failures = 0;

   memory_unit_if ctl_if ();

   assign bus = drv_en ? drv : 8'bz;

   memory_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .ctl         (ctl_if.slave),
      .prog_en     (prog_en),
      .prog_strobe (prog_strobe),
      .prog_nibble (prog_nibble),
      .prog_addr   (prog_addr),
      .prog_hi     (prog_hi),
      .mem_word    (mem_word)
   );

   always #5 clk = ~clk;

   // {nLma, nLmd, nLr, nCE}, active-low
   localparam logic [3:0] IDLE = 4'b1111;
   localparam logic [3:0] LMA  = 4'b0111;
   localparam logic [3:0] LMD  = 4'b1011;
   localparam logic [3:0] LR   = 4'b1101;
   localparam logic [3:0] CE   = 4'b1110;

   // bmode: 0 bench drives bus, 1 expect value, 2 expect released
   typedef struct {
      logic [3:0] c;
      logic       de;
      logic [7:0] d;
      int         bmode;
      logic [7:0] bexp;
      logic [7:0] mexp;
   } vec_t;

   vec_t v [20];

   task automatic set_ctl(input logic [3:0] c);
      ctl_if.nLma = c[3];
      ctl_if.nLmd = c[2];
      ctl_if.nLr  = c[1];
      ctl_if.nCE  = c[0];
   endtask

   task automatic chk(input string name,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Undriven bus reads as Z, or 0 in two-state simulators.
   task automatic chk_rel(input string name);
      checks++;
      if (!(bus === 8'hzz || bus === 8'h00)) begin
         failures++;
         $display("FAIL %s actual=%h expected=released", name, bus);
      end
   endtask

   task automatic cyc(input logic [3:0] c,
                      input logic de,
                      input logic [7:0] d);
      @(negedge clk);
      set_ctl(c);
      drv_en = de;
      drv    = d;
      @(posedge clk);
      #1;
      set_ctl(IDLE);
      drv_en = 1'b0;
   endtask

   task automatic strobe_nibble(input logic [3:0] n);
      @(negedge clk);
      prog_nibble = n;
      prog_strobe = 1'b1;
      repeat (3) @(negedge clk);
      prog_strobe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      v[0]  = '{LMA,      1, 8'h05, 0, 8'h00, 8'h00};
      v[1]  = '{LMD,      1, 8'hA7, 0, 8'h00, 8'h00};
      v[2]  = '{LR,       0, 8'h00, 2, 8'h00, 8'h00};
      v[3]  = '{CE,       0, 8'h00, 1, 8'hA7, 8'hA7};
      v[4]  = '{IDLE,     0, 8'h00, 2, 8'h00, 8'hA7};
      v[5]  = '{LMA,      1, 8'h03, 0, 8'h00, 8'hA7};
      v[6]  = '{LMD,      1, 8'h11, 0, 8'h00, 8'h00};
      v[7]  = '{LR,       0, 8'h00, 2, 8'h00, 8'h00};
      v[8]  = '{LMD,      1, 8'h22, 0, 8'h00, 8'h11};
      v[9]  = '{LR & CE,  0, 8'h00, 1, 8'h11, 8'h11};
      v[10] = '{CE,       0, 8'h00, 1, 8'h22, 8'h22};
      v[11] = '{LMD,      1, 8'h44, 0, 8'h00, 8'h22};
      v[12] = '{LMA & LR, 1, 8'h06, 0, 8'h00, 8'h22};
      v[13] = '{CE,       0, 8'h00, 1, 8'h00, 8'h00};
      v[14] = '{LMA,      1, 8'h03, 0, 8'h00, 8'h00};
      v[15] = '{CE,       0, 8'h00, 1, 8'h44, 8'h44};
      v[16] = '{LMD & LR, 1, 8'h55, 0, 8'h00, 8'h44};
      v[17] = '{CE,       0, 8'h00, 1, 8'h44, 8'h44};
      v[18] = '{LR,       0, 8'h00, 2, 8'h00, 8'h44};
      v[19] = '{CE,       0, 8'h00, 1, 8'h55, 8'h55};

      rst_n       = 1'b0;
      prog_en     = 1'b0;
      prog_strobe = 1'b0;
      prog_nibble = 4'h0;
      drv_en      = 1'b0;
      drv         = 8'h00;
      set_ctl(CE);
      #12;
      chk_rel("rst_bus");
      chk("rst_mem", mem_word, 8'h00);
      chk("rst_paddr", {4'h0, prog_addr}, 8'h00);
      chk("rst_phi", {7'h0, prog_hi}, 8'h00);
      @(negedge clk);
      set_ctl(IDLE);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         set_ctl(v[i].c);
         drv_en = v[i].de;
         drv    = v[i].d;
         #1;
         if (v[i].bmode == 1)
            chk($sformatf("vec%0d_bus", i), bus, v[i].bexp);
         else if (v[i].bmode == 2)
            chk_rel($sformatf("vec%0d_rel", i));
         chk($sformatf("vec%0d_mem", i), mem_word, v[i].mexp);
      end

      // reset between edges while reading RAM[3]
      @(negedge clk);
      set_ctl(CE);
      drv_en = 1'b0;
      #1;
      chk("pre_rst_bus", bus, 8'h55);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mem", mem_word, 8'h00);
      chk_rel("mid_rst_bus");
      chk("mid_rst_paddr", {4'h0, prog_addr}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      set_ctl(IDLE);

      // byte 0 with write-edge timing
      @(negedge clk);
      prog_en = 1'b1;
      strobe_nibble(4'h4);
      chk("lo_phi", {7'h0, prog_hi}, 8'h01);
      @(negedge clk);
      prog_nibble = 4'h3;
      prog_strobe = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("edge2_mem", mem_word, 8'h00);
      chk("edge2_phi", {7'h0, prog_hi}, 8'h01);
      @(posedge clk);
      #1;
      chk("edge3_mem", mem_word, 8'h34);
      chk("edge3_paddr", {4'h0, prog_addr}, 8'h01);
      chk("edge3_phi", {7'h0, prog_hi}, 8'h00);
      @(negedge clk);
      prog_strobe = 1'b0;
      repeat (3) @(negedge clk);

      strobe_nibble(4'hF);
      strobe_nibble(4'h0);
      for (int i = 2; i < 16; i++) begin
         strobe_nibble(4'(i));
         strobe_nibble(4'(15 - i));
      end
      chk("pre_wrap_paddr", {4'h0, prog_addr}, 8'h00);
      strobe_nibble(4'hA);
      strobe_nibble(4'h5);
      chk("wrap_mem", mem_word, 8'h5A);
      chk("wrap_paddr", {4'h0, prog_addr}, 8'h01);

      @(negedge clk);
      prog_en = 1'b0;
      @(posedge clk);
      #1;
      chk("exit_paddr", {4'h0, prog_addr}, 8'h00);
      cyc(LMA, 1'b1, 8'h01);
      chk("ram1", mem_word, 8'h0F);
      cyc(LMA, 1'b1, 8'h07);
      chk("ram7", mem_word, 8'h87);
      cyc(LMA, 1'b1, 8'h0F);
      chk("ram15", mem_word, 8'h0F);
      cyc(LMA, 1'b1, 8'h00);
      chk("ram0", mem_word, 8'h5A);

      // abort a half-loaded byte
      @(negedge clk);
      prog_en = 1'b1;
      strobe_nibble(4'h9);
      chk("abort_phi1", {7'h0, prog_hi}, 8'h01);
      prog_en = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_phi0", {7'h0, prog_hi}, 8'h00);
      chk("abort_paddr", {4'h0, prog_addr}, 8'h00);
      chk("abort_mem", mem_word, 8'h5A);
      @(negedge clk);
      prog_en = 1'b1;
      strobe_nibble(4'h2);
      strobe_nibble(4'h1);
      chk("reload_mem", mem_word, 8'h12);
      chk("reload_paddr", {4'h0, prog_addr}, 8'h01);

      // CPU strobes ignored in programming mode
      cyc(4'b0000, 1'b1, 8'hFF);
      cyc(4'b0000, 1'b1, 8'hFF);
      @(negedge clk);
      set_ctl(4'b0000);
      drv_en = 1'b0;
      #1;
      chk_rel("iso_rel");
      chk("iso_mem", mem_word, 8'h12);
      chk("iso_paddr", {4'h0, prog_addr}, 8'h01);
      @(negedge clk);
      prog_en = 1'b0;
      set_ctl(CE);
      #1;
      chk("iso_read", bus, 8'h12);
      cyc(LR, 1'b0, 8'h00);
      @(negedge clk);
      set_ctl(CE);
      #1;
      chk("iso_mdr", bus, 8'h00);
      @(negedge clk);
      set_ctl(IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
